// File: rtl/fip_accumulator_if.sv
// fip_accumulator_if: beat input and result output bundle of fip_accumulator
interface fip_accumulator_if #(
  parameter int IN_SIZE   = 18,
  parameter int CORR_SIZE = 24,
  parameter int ACC_SIZE  = 32
);
  logic signed [IN_SIZE-1:0]   in_i [0:11];
  logic signed [CORR_SIZE-1:0] corr_i;
  logic                        in_last_i;
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic                        flush_i;
  logic signed [ACC_SIZE-1:0]  out_o;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic                        ovf_o;
  modport master (
    output in_i, corr_i, in_last_i, in_valid_i, flush_i, out_ready_i,
    input  in_ready_o, out_o, out_valid_o, ovf_o
  );
  modport slave (
    input  in_i, corr_i, in_last_i, in_valid_i, flush_i, out_ready_i,
    output in_ready_o, out_o, out_valid_o, ovf_o
  );
endinterface

// File: rtl/fip_accumulator.sv
// fip_accumulator: corrected 12-way partial-product reduce and accumulate over beats; define FIP_ACC_SAT_EN to saturate instead of wrap
module fip_accumulator #(
  parameter int IN_SIZE   = 18,
  parameter int CORR_SIZE = 24,
  parameter int ACC_SIZE  = 32
) (
  input logic              clk_i,
  input logic              rst_ni,
  fip_accumulator_if.slave bus
);
  localparam int SW = (IN_SIZE + 4 > CORR_SIZE ? IN_SIZE + 4 : CORR_SIZE) + 1;
  logic signed [SW-1:0]       beat_sum;
  logic signed [ACC_SIZE-1:0] s1_sum, acc, add_res, out_q;
  logic [ACC_SIZE:0]          wide;
  logic s1_valid, s1_last, sticky, out_valid_q, ovf_q;
  logic consume, accept, load, add_ovf;
  always_comb begin
    beat_sum = -SW'(bus.corr_i);
    for (int k = 0; k < 12; k++) beat_sum = beat_sum + SW'(bus.in_i[k]);
  end
  assign wide    = {acc[ACC_SIZE-1], acc} + {s1_sum[ACC_SIZE-1], s1_sum};
  assign add_ovf = wide[ACC_SIZE] ^ wide[ACC_SIZE-1];
`ifdef FIP_ACC_SAT_EN
  assign add_res = add_ovf ? {wide[ACC_SIZE], {(ACC_SIZE-1){~wide[ACC_SIZE]}}} : wide[ACC_SIZE-1:0];
`else
  assign add_res = wide[ACC_SIZE-1:0];
`endif
  // only a last beat waits on the output register; partial beats always drain
  assign consume        = s1_valid && (!s1_last || !out_valid_q || bus.out_ready_i);
  assign bus.in_ready_o = !bus.flush_i && (!s1_valid || consume);
  assign accept         = bus.in_valid_i && bus.in_ready_o;
  assign load           = consume && s1_last && !bus.flush_i;
  assign bus.out_o       = out_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.ovf_o       = ovf_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc         <= '0;
      sticky      <= 1'b0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_sum      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc         <= bus.flush_i ? '0 : consume ? (s1_last ? '0 : add_res) : acc;
      sticky      <= (bus.flush_i || (consume && s1_last)) ? 1'b0 : sticky | (consume & add_ovf);
      s1_valid    <= !bus.flush_i && (accept || (s1_valid && !consume));
      out_valid_q <= load || (out_valid_q && !bus.out_ready_i);
      if (accept) begin
        s1_sum  <= ACC_SIZE'(beat_sum);
        s1_last <= bus.in_last_i;
      end
      if (load) begin
        out_q <= add_res;
        ovf_q <= add_ovf | sticky;
      end
    end
  end
endmodule
